// File: rtl/elevator_call_scheduler.sv
// rtl/elevator_call_scheduler.sv - call latch, pending register and SCAN direction FSM
// CALL_SCHED_DEBOUNCE_EN: per-floor debounce counters instead of a single-sample edge detector
module elevator_call_scheduler #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DWELL_CYCLES    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] call_in,
  input  logic [1:0] position,
  output logic [3:0] req,
  output logic [3:0] pending,
  output logic       dir_up,
  output logic       moving,
  output logic       door_open
);

  typedef enum logic [1:0] {IDLE, UP, DOWN, DWELL} state_t;

  localparam logic [3:0] DW_LOAD = 4'(DWELL_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 15) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be within 1..15");
  end
  if (DWELL_CYCLES < 1 || DWELL_CYCLES > 15) begin : g_bad_dwell
    $error("DWELL_CYCLES must be within 1..15");
  end

  state_t     state, state_nxt;
  logic [1:0] target, target_nxt;
  logic       dir_up_nxt;
  logic [3:0] dwell_cnt, dwell_nxt;
  logic [3:0] set_vec, clr_vec;

`ifdef CALL_SCHED_DEBOUNCE_EN
  localparam logic [3:0] DB_MAX = 4'(DEBOUNCE_CYCLES);
  logic [3:0][3:0] db_cnt;

  // Counters saturate, so a held button fires set exactly once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!call_in[i])
          db_cnt[i] <= '0;
        else if (db_cnt[i] != DB_MAX)
          db_cnt[i] <= db_cnt[i] + 4'd1;
      end
    end
  end

  always_comb begin
    set_vec = '0;
    for (int i = 0; i < 4; i++)
      set_vec[i] = call_in[i] && (db_cnt[i] == DB_MAX - 4'd1);
  end
`else
  logic [3:0] call_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      call_q <= '0;
    else
      call_q <= call_in;
  end

  assign set_vec = call_in & ~call_q;
`endif

  // Returns {found, floor}: nearest pending floor strictly above pos.
  function automatic logic [2:0] find_above(input logic [3:0] p, input logic [1:0] pos);
    logic [2:0] r;
    r = '0;
    for (int i = 3; i >= 0; i--)
      if (p[i] && i > int'(pos))
        r = {1'b1, 2'(i)};
    return r;
  endfunction

  // Returns {found, floor}: nearest pending floor strictly below pos.
  function automatic logic [2:0] find_below(input logic [3:0] p, input logic [1:0] pos);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)
      if (p[i] && i < int'(pos))
        r = {1'b1, 2'(i)};
    return r;
  endfunction

  logic [2:0] above, below;
  logic       up_ok, dn_ok;
  logic [1:0] up_idx, dn_idx;

  assign above  = find_above(pending, position);
  assign below  = find_below(pending, position);
  assign up_ok  = above[2];
  assign up_idx = above[1:0];
  assign dn_ok  = below[2];
  assign dn_idx = below[1:0];

  always_comb begin
    state_nxt  = state;
    target_nxt = target;
    dir_up_nxt = dir_up;
    dwell_nxt  = dwell_cnt;
    clr_vec    = '0;
    case (state)
      IDLE: begin
        if (pending[position]) begin
          state_nxt         = DWELL;
          clr_vec[position] = 1'b1;
          dwell_nxt         = DW_LOAD;
        end else if (up_ok && (!dn_ok || (up_idx - position) <= (position - dn_idx))) begin
          state_nxt  = UP;
          target_nxt = up_idx;
          dir_up_nxt = 1'b1;
        end else if (dn_ok) begin
          state_nxt  = DOWN;
          target_nxt = dn_idx;
          dir_up_nxt = 1'b0;
        end
      end
      UP, DOWN: begin
        if (position == target) begin
          state_nxt       = DWELL;
          clr_vec[target] = 1'b1;
          dwell_nxt       = DW_LOAD;
        end else if (state == UP && up_ok) begin
          target_nxt = up_idx;
        end else if (state == DOWN && dn_ok) begin
          target_nxt = dn_idx;
        end
      end
      DWELL: begin
        // Calls for the floor the car is standing at are absorbed into this dwell.
        clr_vec[position] = 1'b1;
        if (dwell_cnt != 4'd0) begin
          dwell_nxt = dwell_cnt - 4'd1;
        end else if (dir_up ? up_ok : dn_ok) begin
          state_nxt  = dir_up ? UP : DOWN;
          target_nxt = dir_up ? up_idx : dn_idx;
        end else if (dir_up ? dn_ok : up_ok) begin
          state_nxt  = dir_up ? DOWN : UP;
          target_nxt = dir_up ? dn_idx : up_idx;
          dir_up_nxt = ~dir_up;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      target    <= '0;
      dir_up    <= 1'b0;
      dwell_cnt <= '0;
      pending   <= '0;
    end else begin
      state     <= state_nxt;
      target    <= target_nxt;
      dir_up    <= dir_up_nxt;
      dwell_cnt <= dwell_nxt;
      pending   <= (pending | set_vec) & ~clr_vec;
    end
  end

  assign moving    = (state == UP) || (state == DOWN);
  assign door_open = (state == DWELL);
  assign req       = moving ? (4'b0001 << target) : 4'b0000;

endmodule
